// File: rtl/inst_fetch_unit.sv
// rtl/inst_fetch_unit.sv - instruction fetch: one bus read per PC, registered output with one-entry skid buffer
module inst_fetch_unit #(
    parameter int WORD_WIDTH = 32,
    parameter int W          = WORD_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] pc,
    input  logic         flush,
    input  logic         id_stall,
    output logic         if_stall,
    output logic         mem_req,
    output logic [W-1:0] mem_addr,
    input  logic         mem_ack,
    input  logic [W-1:0] mem_rdata,
    output logic         inst_valid,
    output logic [W-1:0] inst,
    output logic [W-1:0] inst_pc,
    output logic         inst_misalign
);

    localparam logic [W-1:0] ZERO_WORD = '0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_DROP = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [W-1:0] skid_data;
    logic [W-1:0] skid_pc;

    logic ack;
    logic misaligned;
    logic load_ok;
    logic pc_advance;
    logic issue;
    logic req_clr;
    logic load_fetch;
    logic load_mis;
    logic load_skid;
    logic skid_wr;

    // An ack outside a live request is stray and must never be acted on.
    assign ack        = mem_ack && mem_req;
    assign misaligned = (pc[1:0] != 2'b00);
    assign load_ok    = !id_stall || !inst_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (!flush && !misaligned) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (flush) begin
                    state_nxt = ack ? S_IDLE : S_DROP;
                end else if (ack) begin
                    state_nxt = load_ok ? S_IDLE : S_HOLD;
                end
            end
            S_HOLD: begin
                if (flush || !id_stall) state_nxt = S_IDLE;
            end
            S_DROP: begin
                if (ack) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        pc_advance = 1'b0;
        issue      = 1'b0;
        req_clr    = 1'b0;
        load_fetch = 1'b0;
        load_mis   = 1'b0;
        load_skid  = 1'b0;
        skid_wr    = 1'b0;
        case (state)
            S_IDLE: begin
                if (!flush && misaligned && load_ok) begin
                    pc_advance = 1'b1;
                    load_mis   = 1'b1;
                end
                issue = !flush && !misaligned;
            end
            S_WAIT: begin
                req_clr = ack;
                if (ack && !flush) begin
                    pc_advance = 1'b1;
                    load_fetch = load_ok;
                    skid_wr    = !load_ok;
                end
            end
            S_HOLD: begin
                load_skid = !flush && !id_stall;
            end
            S_DROP: begin
                req_clr = ack;
            end
            default: ;
        endcase
    end

    // A flush must let the PC take its branch target regardless of fetch state.
    assign if_stall = flush ? 1'b0 : !pc_advance;

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_req  <= 1'b0;
            mem_addr <= ZERO_WORD;
        end else if (issue) begin
            mem_req  <= 1'b1;
            mem_addr <= pc;
        end else if (req_clr) begin
            mem_req  <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            skid_data <= ZERO_WORD;
            skid_pc   <= ZERO_WORD;
        end else if (skid_wr) begin
            skid_data <= mem_rdata;
            skid_pc   <= mem_addr;
        end else if (state == S_HOLD && (flush || !id_stall)) begin
            skid_data <= ZERO_WORD;
            skid_pc   <= ZERO_WORD;
        end
    end

    // An invalid output slot always reads as a NOP at address zero.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            inst_valid    <= 1'b0;
            inst          <= ZERO_WORD;
            inst_pc       <= ZERO_WORD;
            inst_misalign <= 1'b0;
        end else if (load_fetch) begin
            inst_valid    <= 1'b1;
            inst          <= mem_rdata;
            inst_pc       <= mem_addr;
            inst_misalign <= 1'b0;
        end else if (load_mis) begin
            inst_valid    <= 1'b1;
            inst          <= ZERO_WORD;
            inst_pc       <= pc;
            inst_misalign <= 1'b1;
        end else if (load_skid) begin
            inst_valid    <= 1'b1;
            inst          <= skid_data;
            inst_pc       <= skid_pc;
            inst_misalign <= 1'b0;
        end else if (!id_stall) begin
            inst_valid    <= 1'b0;
            inst          <= ZERO_WORD;
            inst_pc       <= ZERO_WORD;
            inst_misalign <= 1'b0;
        end
    end

endmodule

// File: doc/inst_fetch_unit.md
# inst_fetch_unit

Consumer side of the program counter: takes the current `pc` each time the fetch stage is free, runs one read transaction per instruction on the instruction-memory bus, and presents the fetched word to decode through a registered output stage with a one-entry skid buffer. It drives the PC's `stall` input, so the PC advances exactly once per consumed address. It also handles branch flushes and misaligned fetch addresses.

## Interface

- `W`, default `WORD_WIDTH` (32): address and instruction width.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `pc`  in  W  fetch address from the PC register.
- `flush`  in  1  branch taken or redirect this cycle; kills every fetch in flight.
- `id_stall`  in  1  decode cannot accept a new instruction this cycle.
- `if_stall`  out  1  hold the PC (combinational; equals `!pc_advance`).
- `mem_req`  out  1  bus request, registered.
- `mem_addr`  out  W  bus address, registered; stable while `mem_req` is high.
- `mem_ack`  in  1  single-cycle pulse; `mem_rdata` is valid in that cycle.
- `mem_rdata`  in  W  instruction word.
- `inst_valid`  out  1  the output register holds a live instruction.
- `inst`  out  W  instruction word (`ZERO_WORD` = NOP when invalid or misaligned).
- `inst_pc`  out  W  address of `inst`.
- `inst_misalign`  out  1  the fetch address had `pc[1:0] != 0`.

## Operation

- **States:** IDLE, WAIT, HOLD, DROP.
- **Output register O:** holds {`inst_valid`, `inst`, `inst_pc`, `inst_misalign`}.
  - `load_ok = !id_stall || !inst_valid`.
  - O holds while `id_stall` is high and `inst_valid` is high.
  - In any cycle with `!id_stall` and no load, `inst_valid` goes to 0.
  - `flush` clears `inst_valid` regardless of `id_stall`.
- **`pc_advance`** is high in exactly two cases:
  - IDLE, `!flush`, misaligned `pc`, and `load_ok`.
  - WAIT, `mem_ack`, and `!flush`.
  - During `flush`, `if_stall` is forced to 0 so the PC loads its branch target.
- **IDLE**
  - `flush`: latch nothing; stay in IDLE.
  - `pc[1:0] != 0` and `load_ok`: load O with {1, 0, `pc`, 1}; no bus access; stay in IDLE.
  - `pc[1:0] != 0` and not `load_ok`: stay in IDLE with `if_stall` high.
  - Aligned: `mem_addr <= pc`, `mem_req <= 1`, go to WAIT.
- **WAIT** (`mem_req` is high)
  - `flush` with `mem_ack`: drop the data; `mem_req <= 0`; go to IDLE.
  - `flush` without `mem_ack`: go to DROP.
  - `mem_ack` and `load_ok`: load O with {1, `mem_rdata`, `mem_addr`, 0}; `mem_req <= 0`; go to IDLE.
  - `mem_ack` and not `load_ok`: write {`mem_rdata`, `mem_addr`} into the skid buffer; `mem_req <= 0`; go to HOLD.
- **HOLD**
  - `flush`: discard the skid entry; go to IDLE.
  - `!id_stall`: load O from the skid entry; go to IDLE.
- **DROP**
  - `mem_req` stays high; the bus transaction must complete.
  - On `mem_ack`: discard the data, `mem_req <= 0`, go to IDLE.
  - Further `flush` pulses have no extra effect.
- **Reset**
  - State IDLE; `mem_req` = 0, `mem_addr` = 0; O = {0, 0, 0, 0}; skid buffer cleared.
  - A transaction in flight is abandoned. The bus slave shares `rst` and must abort its own transaction on reset.
- **Bus rules:** `mem_ack` is ignored whenever `mem_req` is low.

## Timing

- Request latency: `pc` is sampled in IDLE in cycle N; `mem_req` is high from N+1.
- `mem_ack` may arrive in N+1 at the earliest, or any cycle later.
- With ack in cycle A, `inst_valid` is high in cycle A+1 and the PC presents the next address in cycle A+1.
- Peak throughput is one instruction per 2 cycles with zero-wait memory.
- A misaligned address produces its O entry one cycle after it is sampled.
- Every flush is followed by at least one idle fetch cycle; no instruction from before the flush ever reaches O after it.

## Test plan

- **Zero-wait stream.** Aligned `pc` = 0, 4, 8 with `mem_ack` in every WAIT cycle and data 0x11, 0x22, 0x33.
  - Required: `inst`/`inst_pc` = (0x11, 0), (0x22, 4), (0x33, 8), each with `inst_valid` high for 1 cycle, 2 cycles apart.
- **Slow memory.** `mem_ack` 3 cycles after `mem_req` rises.
  - Required: `mem_addr` stable and `if_stall` high for the whole wait; `inst_valid` rises 1 cycle after the ack.
- **Skid buffer.** `id_stall` high while an ack arrives with O already valid (0x22).
  - Required: O holds 0x22; the new word (0x33) goes to HOLD.
  - Required: after `id_stall` drops, 0x33 appears next cycle and nothing is lost or duplicated.
- **Flush mid-request.** Flush 1 cycle into WAIT, ack 2 cycles later with 0xDEAD.
  - Required: state goes to DROP; 0xDEAD never appears on `inst`.
  - Required: the next fetch uses the branch target, and `inst_valid` is cleared on the flush cycle.
- **Misaligned PC.** `pc` = 0x6.
  - Required: no `mem_req`; next cycle O = {1, 0, 0x6, 1}; `if_stall` low in the sampling cycle.
- **Reset during WAIT.** Assert `rst` while `mem_req` is high.
  - Required: next cycle all outputs are 0 and state is IDLE; a late `mem_ack` is ignored.
